// File: rtl/axis_traffic_gen.sv
// Uniform-random single-flit AXI-Stream packet source, stamping tick and per-destination sequence.
// Optional macro AXIS_TG_NO_SELF_EN remaps self-addressed flits to the next router.
module axis_traffic_gen #(
  parameter int          COUNT_WIDTH = 32,
  parameter int          TID         = 0,
  parameter int          TDATA_WIDTH = 512,
  parameter int          TDEST_WIDTH = 2,
  parameter int          TID_WIDTH   = 2,
  parameter int          NUM_ROUTERS = 2,
  parameter int          RATE        = 128,
  parameter int          NUM_PACKETS = 0,
  parameter logic [31:0] SEED        = 32'hACE1_2468
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [TDATA_WIDTH/2-1:0]           ticks,
  input  logic                               enable,
  output logic [NUM_ROUTERS*COUNT_WIDTH-1:0] sent_packets,
  output logic [COUNT_WIDTH-1:0]             total_sent_packets,
  output logic                               done,
  output logic                               axis_out_tvalid,
  input  logic                               axis_out_tready,
  output logic [TDATA_WIDTH-1:0]             axis_out_tdata,
  output logic                               axis_out_tlast,
  output logic [TID_WIDTH-1:0]               axis_out_tid,
  output logic [TDEST_WIDTH-1:0]             axis_out_tdest
);

  localparam int                     HALF      = TDATA_WIDTH / 2;
  localparam logic [31:0]            LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0]            SEED_MIX  = SEED ^ 32'(TID);
  localparam logic [31:0]            LFSR_INIT = (SEED_MIX == 32'd0) ? 32'd1 : SEED_MIX;
  localparam logic [8:0]             RATE9     = 9'(RATE);
  localparam logic [15:0]            NR16      = 16'(NUM_ROUTERS);
  localparam logic [COUNT_WIDTH-1:0] LIMIT     = COUNT_WIDTH'(NUM_PACKETS);
  localparam logic                   LIMIT_EN  = (NUM_PACKETS != 0);
  localparam logic [TDEST_WIDTH-1:0] TID_D     = TDEST_WIDTH'(TID);
  localparam logic [TDEST_WIDTH-1:0] ALT_D     = TDEST_WIDTH'((TID + 1) % NUM_ROUTERS);
`ifdef AXIS_TG_NO_SELF_EN
  localparam logic                   DEST_OK   = (NUM_ROUTERS > 1);
`else
  localparam logic                   DEST_OK   = 1'b1;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 state_r, state_next_s;
  logic [31:0]            lfsr_r, lfsr_next_s;
  logic                   tvalid_r;
  logic [TDATA_WIDTH-1:0] tdata_r, tdata_next_s;
  logic [TDEST_WIDTH-1:0] tdest_r, raw_dest_s, dest_s;
  logic [COUNT_WIDTH-1:0] sent_r [NUM_ROUTERS];
  logic [COUNT_WIDTH-1:0] total_r, seq_s;
  logic                   hs_s, last_hs_s, eligible_s, inject_s;

  // Slot control: handshake, limit detection, injection decision and next flit contents.
  always_comb begin
    hs_s        = tvalid_r & axis_out_tready;
    last_hs_s   = hs_s & LIMIT_EN & ((total_r + COUNT_WIDTH'(1)) == LIMIT);
    lfsr_next_s = lfsr_r[0] ? ({1'b0, lfsr_r[31:1]} ^ LFSR_MASK) : {1'b0, lfsr_r[31:1]};
    raw_dest_s  = TDEST_WIDTH'(lfsr_r[31:16] % NR16);
`ifdef AXIS_TG_NO_SELF_EN
    dest_s      = (raw_dest_s == TID_D) ? ALT_D : raw_dest_s;
`else
    dest_s      = raw_dest_s;
`endif
    eligible_s  = (state_r == S_ACTIVE) & enable & (~tvalid_r | hs_s) & ~last_hs_s;
    inject_s    = eligible_s & DEST_OK & ({1'b0, lfsr_r[7:0]} < RATE9);
    // A handshake to the same destination in this cycle already counts toward the new seq.
    seq_s = '0;
    for (int r = 0; r < NUM_ROUTERS; r++) begin
      seq_s = (dest_s == TDEST_WIDTH'(r))
            ? (sent_r[r] + ((hs_s && (tdest_r == TDEST_WIDTH'(r))) ? COUNT_WIDTH'(1) : COUNT_WIDTH'(0)))
            : seq_s;
    end
    tdata_next_s                    = '0;
    tdata_next_s[TDATA_WIDTH-1:HALF] = ticks;
    tdata_next_s[COUNT_WIDTH-1:0]    = seq_s;
  end

  // Next-state logic; DONE is only left through reset.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:   state_next_s = enable ? S_ACTIVE : S_IDLE;
      S_ACTIVE: begin
        if (last_hs_s) begin
          state_next_s = S_DONE;
        end else if (!enable && !tvalid_r) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_ACTIVE;
        end
      end
      S_DONE:   state_next_s = S_DONE;
      default:  state_next_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // LFSR and output slot; payload is held until the flit is handshaken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r   <= LFSR_INIT;
      tvalid_r <= 1'b0;
      tdata_r  <= '0;
      tdest_r  <= '0;
    end else begin
      if (state_r == S_ACTIVE) begin
        lfsr_r <= lfsr_next_s;
      end
      if (inject_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= tdata_next_s;
        tdest_r  <= dest_s;
      end else if (hs_s) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  // Handshake counters, wrapping at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_r <= '0;
      for (int r = 0; r < NUM_ROUTERS; r++) sent_r[r] <= '0;
    end else if (hs_s) begin
      total_r <= total_r + COUNT_WIDTH'(1);
      for (int r = 0; r < NUM_ROUTERS; r++) begin
        if (tdest_r == TDEST_WIDTH'(r)) sent_r[r] <= sent_r[r] + COUNT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_ROUTERS; g++) begin : g_sent
    assign sent_packets[g*COUNT_WIDTH +: COUNT_WIDTH] = sent_r[g];
  end

  assign total_sent_packets = total_r;
  assign done               = (state_r == S_DONE);
  assign axis_out_tvalid    = tvalid_r;
  assign axis_out_tdata     = tdata_r;
  assign axis_out_tdest     = tdest_r;
  assign axis_out_tlast     = 1'b1;
  assign axis_out_tid       = TID_WIDTH'(TID);

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: cycle model of the main stream plus limit, rate and reset cases.
module tb_axis_traffic_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [63:0] ticks = '0;
  always @(posedge clk) ticks <= ticks + 64'd1;

  int n_assert = 0;
  int n_fail   = 0;

  logic m_en, m_ready, m_tvalid, m_tlast, m_done;
  logic [127:0] m_tdata, m_sent;
  logic [1:0] m_tid, m_tdest;
  logic [31:0] m_total;
  logic l_en, l_ready, l_tvalid, l_tlast, l_done;
  logic [127:0] l_tdata, l_sent;
  logic [1:0] l_tid, l_tdest;
  logic [31:0] l_total;
  logic z_en, z_ready, z_tvalid, z_tlast, z_done;
  logic [127:0] z_tdata;
  logic [63:0] z_sent;
  logic [1:0] z_tid, z_tdest;
  logic [31:0] z_total;
  logic r_en, r_ready, r_tvalid, r_tlast, r_done;
  logic [127:0] r_tdata;
  logic [63:0] r_sent;
  logic [1:0] r_tid, r_tdest;
  logic [31:0] r_total;

  axis_traffic_gen #(.COUNT_WIDTH(32), .TID(0), .TDATA_WIDTH(128), .NUM_ROUTERS(4), .RATE(256), .NUM_PACKETS(0))
  u_main (.clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(m_en), .sent_packets(m_sent),
          .total_sent_packets(m_total), .done(m_done), .axis_out_tvalid(m_tvalid), .axis_out_tready(m_ready),
          .axis_out_tdata(m_tdata), .axis_out_tlast(m_tlast), .axis_out_tid(m_tid), .axis_out_tdest(m_tdest));

  axis_traffic_gen #(.COUNT_WIDTH(32), .TID(1), .TDATA_WIDTH(128), .NUM_ROUTERS(4), .RATE(256), .NUM_PACKETS(5))
  u_lim (.clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(l_en), .sent_packets(l_sent),
         .total_sent_packets(l_total), .done(l_done), .axis_out_tvalid(l_tvalid), .axis_out_tready(l_ready),
         .axis_out_tdata(l_tdata), .axis_out_tlast(l_tlast), .axis_out_tid(l_tid), .axis_out_tdest(l_tdest));

  axis_traffic_gen #(.COUNT_WIDTH(32), .TID(0), .TDATA_WIDTH(128), .NUM_ROUTERS(2), .RATE(0), .NUM_PACKETS(0))
  u_zero (.clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(z_en), .sent_packets(z_sent),
          .total_sent_packets(z_total), .done(z_done), .axis_out_tvalid(z_tvalid), .axis_out_tready(z_ready),
          .axis_out_tdata(z_tdata), .axis_out_tlast(z_tlast), .axis_out_tid(z_tid), .axis_out_tdest(z_tdest));

  axis_traffic_gen #(.COUNT_WIDTH(32), .TID(1), .TDATA_WIDTH(128), .NUM_ROUTERS(2), .RATE(64), .NUM_PACKETS(0))
  u_r64 (.clk(clk), .rst_n(rst_n), .ticks(ticks), .enable(r_en), .sent_packets(r_sent),
         .total_sent_packets(r_total), .done(r_done), .axis_out_tvalid(r_tvalid), .axis_out_tready(r_ready),
         .axis_out_tdata(r_tdata), .axis_out_tlast(r_tlast), .axis_out_tid(r_tid), .axis_out_tdest(r_tdest));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
  endfunction

  // Reference model of the main instance (TID=0, 4 routers, RATE=256, no limit).
  logic [31:0] mdl_lfsr, mdl_total, mdl_seq;
  logic [31:0] mdl_cnt [4];
  logic        mdl_vld, mdl_active;
  logic [1:0]  mdl_dest;
  logic [63:0] mdl_tick;

  task automatic model_reset();
    mdl_lfsr = 32'hACE1_2468;
    mdl_total = 32'd0;
    mdl_seq = 32'd0;
    mdl_vld = 1'b0;
    mdl_active = 1'b0;
    mdl_dest = 2'd0;
    mdl_tick = 64'd0;
    for (int i = 0; i < 4; i++) mdl_cnt[i] = 32'd0;
  endtask

  task automatic main_cycle(input string tag);
    logic hs, vld_old;
    logic [1:0] nd;
    check({tag, "_tvalid"}, 128'(m_tvalid), 128'(mdl_vld));
    if (mdl_vld) begin
      check({tag, "_tdest"}, 128'(m_tdest), 128'(mdl_dest));
      check({tag, "_tdata"}, m_tdata, {mdl_tick, 32'd0, mdl_seq});
    end
    check({tag, "_total"}, 128'(m_total), 128'(mdl_total));
    check({tag, "_sent"}, m_sent, {mdl_cnt[3], mdl_cnt[2], mdl_cnt[1], mdl_cnt[0]});
    vld_old = mdl_vld;
    hs = mdl_vld && m_ready;
    if (mdl_active) begin
      if (hs) begin
        mdl_cnt[mdl_dest] = mdl_cnt[mdl_dest] + 32'd1;
        mdl_total = mdl_total + 32'd1;
      end
      if (m_en && (!vld_old || hs)) begin
        nd = 2'(mdl_lfsr[31:16] % 16'd4);
        mdl_dest = nd;
        mdl_seq = mdl_cnt[nd];
        mdl_tick = ticks;
        mdl_vld = 1'b1;
      end else if (hs) begin
        mdl_vld = 1'b0;
      end
      if (!m_en && !vld_old) mdl_active = 1'b0;
      mdl_lfsr = lfsr_adv(mdl_lfsr);
    end else if (m_en) begin
      mdl_active = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    int n_hs, z_cnt, r_cnt;
    rst_n = 1'b0;
    m_en = 1'b0; l_en = 1'b0; z_en = 1'b0; r_en = 1'b0;
    m_ready = 1'b1; l_ready = 1'b1; z_ready = 1'b1; r_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    check("rst_m_tvalid", 128'(m_tvalid), 128'(1'b0));
    check("rst_m_tdata", m_tdata, 128'd0);
    check("rst_m_tdest", 128'(m_tdest), 128'(2'd0));
    check("rst_m_total", 128'(m_total), 128'd0);
    check("rst_m_sent", m_sent, 128'd0);
    check("rst_m_done", 128'(m_done), 128'(1'b0));
    check("rst_m_tlast", 128'(m_tlast), 128'(1'b1));
    check("rst_m_tid", 128'(m_tid), 128'(2'd0));
    check("rst_l_tid", 128'(l_tid), 128'(2'd1));
    check("rst_l_tlast", 128'(l_tlast), 128'(1'b1));
    check("rst_l_tdata", l_tdata, 128'd0);
    check("rst_l_tdest", 128'(l_tdest), 128'(2'd0));
    check("rst_z_tdata", {z_tdata[127:2], z_tdest}, 128'd0);
    check("rst_z_misc", {z_sent, 61'd0, z_tid, z_tlast}, 128'd1);
    check("rst_r_tdata", {r_tdata[127:2], r_tdest}, 128'd0);
    check("rst_r_misc", {r_sent, 61'd0, r_tid, r_tlast}, {64'd0, 61'd0, 2'd1, 1'b1});

    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_valid", 128'(m_tvalid), 128'(1'b0));

    // Main stream with a 20-cycle stall in the middle.
    m_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      m_ready = !(c >= 40 && c < 60);
      main_cycle("main");
    end

    // Enable falls during a stall: the pending flit stays until handshaken.
    m_ready = 1'b0;
    m_en = 1'b0;
    for (int c = 0; c < 5; c++) main_cycle("endrop_stall");
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) main_cycle("endrop_rel");
    m_en = 1'b1;
    for (int c = 0; c < 10; c++) main_cycle("reen");

    // Packet limit of five.
    check("lim_done_pre", 128'(l_done), 128'(1'b0));
    l_en = 1'b1;
    n_hs = 0;
    for (int c = 0; c < 20; c++) begin
      if (l_tvalid && l_ready) n_hs++;
      @(negedge clk);
    end
    check("lim_handshakes", 128'(n_hs), 128'(5));
    check("lim_done", 128'(l_done), 128'(1'b1));
    check("lim_tvalid", 128'(l_tvalid), 128'(1'b0));
    check("lim_total", 128'(l_total), 128'd5);
    check("lim_sent_sum", 128'(l_sent[31:0] + l_sent[63:32] + l_sent[95:64] + l_sent[127:96]), 128'd5);
    repeat (10) @(negedge clk);
    check("lim_tvalid_late", 128'(l_tvalid), 128'(1'b0));
    check("lim_done_late", 128'(l_done), 128'(1'b1));

    // RATE=0 never injects; RATE=64 injects about a quarter of the time.
    z_en = 1'b1;
    r_en = 1'b1;
    z_cnt = 0;
    r_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c < 1000 && z_tvalid) z_cnt++;
      if (r_tvalid && r_ready) r_cnt++;
      @(negedge clk);
    end
    check("zero_valid_cycles", 128'(z_cnt), 128'd0);
    check("zero_total", 128'(z_total), 128'd0);
    check("r64_rate", 128'((r_total >= 32'd2250) && (r_total <= 32'd2750)), 128'(1'b1));
    check("r64_total_vs_hs", 128'(r_total), 128'(r_cnt));
    check("r64_sent_sum", 128'(r_sent[31:0] + r_sent[63:32]), 128'(r_cnt));
    check("zr_done", 128'({z_done, r_done}), 128'(2'b00));
    check("main_done", 128'(m_done), 128'(1'b0));

    // Asynchronous reset mid-cycle while the main slot is full.
    check("pre_rst_valid", 128'(m_tvalid), 128'(1'b1));
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 128'(m_tvalid), 128'(1'b0));
    check("arst_total", 128'(m_total), 128'd0);
    check("arst_sent", m_sent, 128'd0);
    check("arst_tdata", m_tdata, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 30; c++) main_cycle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
